sta_tile_ctrl: RTL and testbench
================================

Name: sta_tile_ctrl

Overview:
Sequencer for one N x N systolic tile of DP processing elements. On start it:
- clears the PE accumulators;
- drives skewed per-lane read enables and addresses into the data and weight operand buffers for a programmable reduction length K;
- waits for the array to drain;
- hands out the N result rows over a valid/ready port, then pulses done.

It sits between the layer scheduler (start/done) and the tile datapath plus its operand buffers.

Parameters:
N, 4, tile dimension (rows = cols = lanes), N >= 2
K_MAX, 64, maximum reduction length per job
PE_LAT, 1, register stages per PE hop
KW, $clog2(K_MAX+1), width of k_len_i
AW, $clog2(K_MAX), operand buffer address width
RW, $clog2(N), result row index width

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  synchronous, active-high reset
start_i  in  1  job request, sampled only in IDLE
k_len_i  in  KW  reduction length K, sampled with accepted start
abort_i  in  1  synchronous abort of the current job
busy_o  out  1  high in every state except IDLE
acc_clr_o  out  1  one-cycle accumulator clear to all PEs
pe_en_o  out  1  array compute/shift enable
lane_en_o  out  N  per-lane operand buffer read enable (bit r = lane r)
lane_addr_o  out  N*AW  packed per-lane read address, lane r at [r*AW +: AW]
out_valid_o  out  1  result row available
out_ready_i  in  1  consumer accepts result row
out_row_o  out  RW  index of the row being presented
done_o  out  1  one-cycle job-complete pulse

Behaviour:
- Reset: one clock with reset_i=1 forces state IDLE and all counters to 0.
  - All outputs are 0 at reset.
  - Reset has priority over abort_i and start_i and applies in any state, including mid-job.
- States: IDLE, CLEAR, FEED, DRAIN, READOUT, DONE.
- IDLE to CLEAR: on start_i=1 with 1 <= k_len_i <= K_MAX. K is latched.
  - start_i with k_len_i = 0 or k_len_i > K_MAX is ignored; the block stays in IDLE.
- CLEAR: exactly 1 cycle, with acc_clr_o=1 and pe_en_o=0. Then go to FEED with t=0.
- FEED: lasts K+N-1 cycles, t = 0..K+N-2.
  - pe_en_o=1 throughout.
  - lane_en_o[r] = 1 iff r <= t < r+K.
  - lane_addr_o lane r = t-r when enabled, else 0.
  - Lane r's first read is therefore r cycles after lane 0's, which produces the systolic skew.
- DRAIN: lasts N*PE_LAT cycles with pe_en_o=1 and all lane_en_o=0.
- READOUT: out_valid_o=1 and out_row_o = row counter, starting at 0; pe_en_o=0.
  - Row counter increments on out_valid_o & out_ready_i.
  - out_row_o holds stable while out_ready_i=0.
  - The handshake on row N-1 moves the block to DONE.
- DONE: 1 cycle with done_o=1 and busy_o=1, then IDLE.
  - A new start is accepted no earlier than the cycle after DONE.
- start_i while busy: ignored; no queuing.
- abort_i=1 in any non-IDLE state: next cycle is IDLE with all outputs 0 and no done_o.
  - An in-progress row handshake in that cycle is discarded.
- Outputs are registered, with no combinational path from inputs to outputs.
  - Exception: none; out_ready_i affects only the next-cycle row counter and state.
- Counters are wide enough for K_MAX+N-1 without wrap. lane_addr_o never exceeds K-1.

Test Plan:
1. Reset, N=4, K=3, start for one cycle:
   - acc_clr_o=1 for exactly 1 cycle.
   - FEED lasts 6 cycles. lane 0 enabled t=0..2 with addr 0,1,2; lane 3 enabled t=3..5 with addr 0,1,2.
   - DRAIN lasts 4 cycles, then out_valid_o=1 with out_row_o=0.
2. Readout backpressure, out_ready_i pattern 1,0,0,1,1,1:
   - out_row_o sequence is 0,1,1,1,2,3.
   - done_o pulses exactly once, 1 cycle after the row-3 handshake, and busy_o falls the cycle after that.
3. Boundaries:
   - k_len_i=0 or K_MAX+1 with start_i: stays in IDLE, busy_o stays 0.
   - k_len_i=K_MAX: FEED lasts K_MAX+N-1 cycles, and the last lane-3 address is K_MAX-1.
4. start_i held high during FEED and READOUT:
   - No restart and no extra acc_clr_o.
   - A second start issued the cycle after done_o is accepted.
5. Abort and reset mid-job:
   - abort_i in FEED at t=2: next cycle IDLE, all outputs 0, no done_o.
   - reset_i in READOUT: same outputs as abort; a new job afterwards runs cleanly per scenario 1.

Source files
------------

// File: rtl/sta_tile_ctrl.sv
// -----------------------------------------------------------------------------
// sta_tile_ctrl
//
// Sequencer for one N x N systolic tile of processing elements. A job runs
// through the following phases:
//   - clear the PE accumulators;
//   - stream K skewed operand reads per lane;
//   - let the array drain;
//   - present the N result rows over a valid/ready port;
//   - pulse done.
//
// Ports
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset (priority over everything)
//   start_i      job request, only looked at in IDLE
//   k_len_i      reduction length K, latched with an accepted start
//   abort_i      synchronous abort of the running job
//   busy_o       high in every state except IDLE
//   acc_clr_o    one-cycle accumulator clear to all PEs
//   pe_en_o      array compute/shift enable (FEED and DRAIN)
//   lane_en_o    per-lane operand buffer read enable, bit r = lane r
//   lane_addr_o  packed per-lane read address, lane r at [r*AW +: AW]
//   out_valid_o  result row available
//   out_ready_i  consumer accepts the presented result row
//   out_row_o    index of the row being presented
//   done_o       one-cycle job-complete pulse
//
// Result handshake: a row transfers on a cycle where out_valid_o and
// out_ready_i are both high. Once out_valid_o rises it stays high and
// out_row_o stays stable until that transfer happens, unless the job is
// aborted or reset. out_valid_o never depends on out_ready_i.
//
// Every output is a flop loaded from the next-state values. Inputs therefore
// reach the outputs only through a register.
// -----------------------------------------------------------------------------
module sta_tile_ctrl #(
    parameter int N      = 4,
    parameter int K_MAX  = 64,
    parameter int PE_LAT = 1,
    parameter int KW     = $clog2(K_MAX + 1),
    parameter int AW     = $clog2(K_MAX),
    parameter int RW     = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [KW-1:0]   k_len_i,
    input  logic            abort_i,
    output logic            busy_o,
    output logic            acc_clr_o,
    output logic            pe_en_o,
    output logic [N-1:0]    lane_en_o,
    output logic [N*AW-1:0] lane_addr_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [RW-1:0]   out_row_o,
    output logic            done_o
);

    localparam int DRAIN_LEN = N * PE_LAT;
    // The phase counter covers the longest FEED (K_MAX+N-1 cycles) and the
    // DRAIN length without wrapping.
    localparam int CW = $clog2(K_MAX + N + DRAIN_LEN);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        FEED    = 3'd2,
        DRAIN   = 3'd3,
        READOUT = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] t, t_n;        // FEED step / DRAIN cycle counter
    logic [KW-1:0] k, k_n;        // latched reduction length
    logic [RW-1:0] row, row_n;    // next result row to hand out
    logic [CW-1:0] feed_last;

    logic            busy_n, clr_n, pe_n, valid_n, done_n;
    logic [N-1:0]    lane_en_n;
    logic [N*AW-1:0] lane_addr_n;
    logic [RW-1:0]   out_row_n;

    // The last FEED step is t = K+N-2, when lane N-1 does its final read.
    assign feed_last = CW'(k) + CW'(N - 2);

    // Next-state and counter logic.
    always_comb begin
        state_n = state;
        t_n     = t;
        k_n     = k;
        row_n   = row;
        case (state)
            IDLE: begin
                if (start_i && (k_len_i != '0) && (k_len_i <= KW'(K_MAX))) begin
                    state_n = CLEAR;
                    k_n     = k_len_i;
                    t_n     = '0;
                    row_n   = '0;
                end
            end
            CLEAR: begin
                state_n = FEED;
                t_n     = '0;
            end
            FEED: begin
                if (t == feed_last) begin
                    state_n = DRAIN;
                    t_n     = '0;
                end else begin
                    t_n = t + CW'(1);
                end
            end
            DRAIN: begin
                if (t == CW'(DRAIN_LEN - 1)) begin
                    state_n = READOUT;
                    t_n     = '0;
                    row_n   = '0;
                end else begin
                    t_n = t + CW'(1);
                end
            end
            READOUT: begin
                // out_valid_o is high throughout READOUT, so a transfer
                // happens exactly when out_ready_i is high.
                if (out_ready_i) begin
                    if (row == RW'(N - 1)) begin
                        state_n = DONE;
                        row_n   = '0;
                    end else begin
                        row_n = row + RW'(1);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort wins over any transition. A row transfer in the same cycle
        // is dropped along with the job.
        if (abort_i && (state != IDLE)) begin
            state_n = IDLE;
            t_n     = '0;
            k_n     = '0;
            row_n   = '0;
        end
    end

    // Output values decoded from the next state, registered below.
    always_comb begin
        busy_n      = (state_n != IDLE);
        clr_n       = (state_n == CLEAR);
        pe_n        = (state_n == FEED) || (state_n == DRAIN);
        valid_n     = (state_n == READOUT);
        out_row_n   = (state_n == READOUT) ? row_n : '0;
        done_n      = (state_n == DONE);
        lane_en_n   = '0;
        lane_addr_n = '0;
        if (state_n == FEED) begin
            // Lane r reads during steps r .. r+K-1 from address t-r, which
            // delays each lane by one cycle relative to the lane before it.
            for (int r = 0; r < N; r++) begin
                if ((t_n >= CW'(r)) && (t_n < (CW'(r) + CW'(k_n)))) begin
                    lane_en_n[r]            = 1'b1;
                    lane_addr_n[r*AW +: AW] = AW'(t_n - CW'(r));
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            t           <= '0;
            k           <= '0;
            row         <= '0;
            busy_o      <= 1'b0;
            acc_clr_o   <= 1'b0;
            pe_en_o     <= 1'b0;
            lane_en_o   <= '0;
            lane_addr_o <= '0;
            out_valid_o <= 1'b0;
            out_row_o   <= '0;
            done_o      <= 1'b0;
        end else begin
            state       <= state_n;
            t           <= t_n;
            k           <= k_n;
            row         <= row_n;
            busy_o      <= busy_n;
            acc_clr_o   <= clr_n;
            pe_en_o     <= pe_n;
            lane_en_o   <= lane_en_n;
            lane_addr_o <= lane_addr_n;
            out_valid_o <= valid_n;
            out_row_o   <= out_row_n;
            done_o      <= done_n;
        end
    end

endmodule

// File: tb/tb_sta_tile_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sta_tile_ctrl
//
// Directed and randomised jobs for sta_tile_ctrl. Before each job, the bench
// builds the complete cycle-by-cycle output trace from the phase lengths and
// the lane-window rule:
//   - one clear cycle;
//   - K+N-1 feed steps;
//   - N*PE_LAT drain cycles;
//   - readout paced by the ready pattern;
//   - a done cycle;
//   - an idle cycle.
// The trace goes into an expected queue. The bench then replays the job
// against the DUT one cycle at a time.
// -----------------------------------------------------------------------------
module tb_sta_tile_ctrl;

    localparam int N      = 4;
    localparam int K_MAX  = 64;
    localparam int PE_LAT = 1;
    localparam int KW     = $clog2(K_MAX + 1);
    localparam int AW     = $clog2(K_MAX);
    localparam int RW     = $clog2(N);
    localparam int W      = 3 + N + N*AW + 1 + RW + 1;

    // ---------------------------------------------------------------- clock/reset
    logic            clk_i = 1'b0;
    logic            reset_i;
    logic            start_i;
    logic [KW-1:0]   k_len_i;
    logic            abort_i;
    logic            busy_o;
    logic            acc_clr_o;
    logic            pe_en_o;
    logic [N-1:0]    lane_en_o;
    logic [N*AW-1:0] lane_addr_o;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [RW-1:0]   out_row_o;
    logic            done_o;

    always #5 clk_i = ~clk_i;

    sta_tile_ctrl #(
        .N(N), .K_MAX(K_MAX), .PE_LAT(PE_LAT), .KW(KW), .AW(AW), .RW(RW)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .k_len_i     (k_len_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .acc_clr_o   (acc_clr_o),
        .pe_en_o     (pe_en_o),
        .lane_en_o   (lane_en_o),
        .lane_addr_o (lane_addr_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_row_o   (out_row_o),
        .done_o      (done_o)
    );

    // ---------------------------------------------------------------- scoreboard
    logic [W-1:0] exp_q[$];
    logic         rdy_q[$];     // out_ready_i to drive during each trace cycle
    logic         rdy_pat[$];   // optional fixed ready pattern for readout
    int           tests = 0;
    int           fails = 0;

    function automatic logic [W-1:0] mk(input logic busy, input logic clr,
                                        input logic pe, input logic [N-1:0] en,
                                        input logic [N*AW-1:0] ad, input logic v,
                                        input logic [RW-1:0] row, input logic dn);
        return {busy, clr, pe, en, ad, v, row, dn};
    endfunction

    function automatic logic [W-1:0] observed();
        return {busy_o, acc_clr_o, pe_en_o, lane_en_o, lane_addr_o,
                out_valid_o, out_row_o, done_o};
    endfunction

    task automatic check(input logic [W-1:0] e, input string tag);
        logic [W-1:0] o;
        o = observed();
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic logic rnd_bit();
        return ($urandom_range(0, 1) == 1);
    endfunction

    // Build the expected trace of one job. stop_at >= 0 truncates the trace
    // after that cycle, and one all-zero IDLE cycle follows (abort or reset).
    task automatic build_job(input int k, input int stop_at);
        logic [N-1:0]    en;
        logic [N*AW-1:0] ad;
        logic            r;
        int              row;
        exp_q.delete();
        rdy_q.delete();
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0));
        rdy_q.push_back(rnd_bit());
        for (int t = 0; t <= k + N - 2; t++) begin
            en = '0;
            ad = '0;
            for (int l = 0; l < N; l++) begin
                if (t >= l && t < l + k) begin
                    en[l]          = 1'b1;
                    ad[l*AW +: AW] = AW'(t - l);
                end
            end
            exp_q.push_back(mk(1'b1, 1'b0, 1'b1, en, ad, 1'b0, '0, 1'b0));
            rdy_q.push_back(rnd_bit());
        end
        for (int d = 0; d < N*PE_LAT; d++) begin
            exp_q.push_back(mk(1'b1, 1'b0, 1'b1, '0, '0, 1'b0, '0, 1'b0));
            rdy_q.push_back(rnd_bit());
        end
        row = 0;
        while (row < N) begin
            if (rdy_pat.size() > 0) r = rdy_pat.pop_front();
            else                    r = rnd_bit();
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, RW'(row), 1'b0));
            rdy_q.push_back(r);
            if (r) row++;
        end
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1));
        rdy_q.push_back(rnd_bit());
        exp_q.push_back('0);
        rdy_q.push_back(rnd_bit());
        if (stop_at >= 0 && stop_at < exp_q.size() - 1) begin
            while (exp_q.size() > stop_at + 1) begin
                void'(exp_q.pop_back());
                void'(rdy_q.pop_back());
            end
            exp_q.push_back('0);
            rdy_q.push_back(rnd_bit());
        end
    endtask

    // ---------------------------------------------------------------- driver
    // stop_kind: 0 none, 1 abort, 2 reset, applied during trace cycle stop_at.
    task automatic run_job(input int k, input int stop_at, input int stop_kind,
                           input logic hold, input string name);
        logic [W-1:0] e;
        int           idx;
        build_job(k, stop_at);
        start_i = 1'b1;
        k_len_i = KW'(k);
        abort_i = 1'b0;
        reset_i = 1'b0;
        idx     = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk_i);
            #1;
            e = exp_q.pop_front();
            check(e, $sformatf("%s k=%0d cyc=%0d", name, k, idx));
            out_ready_i = rdy_q.pop_front();
            if (exp_q.size() == 0) start_i = 1'b0;
            else                   start_i = hold ? 1'b1 : rnd_bit();
            k_len_i = KW'($urandom_range(1, K_MAX));
            abort_i = (stop_kind == 1) && (idx == stop_at);
            reset_i = (stop_kind == 2) && (idx == stop_at);
            idx++;
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        reset_i = 1'b0;
    endtask

    // Idle cycles. With bad=1, start_i is held with an illegal length.
    task automatic idle_check(input int n, input logic bad, input string name);
        for (int i = 0; i < n; i++) begin
            start_i     = bad;
            k_len_i     = (i % 2 == 0) ? KW'(0) : KW'(K_MAX + 1);
            out_ready_i = rnd_bit();
            @(posedge clk_i);
            #1;
            check('0, $sformatf("%s cyc=%0d", name, i));
        end
        start_i = 1'b0;
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        int k;
        int l0;
        int stop_at;
        int kind;
        reset_i     = 1'b1;
        start_i     = 1'b1;
        k_len_i     = KW'(3);
        abort_i     = 1'b1;
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check('0, "reset_state");
        @(posedge clk_i);
        #1;
        check('0, "reset_held");
        reset_i = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        idle_check(2, 1'b0, "idle_after_reset");

        // K=3 job; readout ready pattern 1,0,0,1,1,1 -> rows 0,1,1,1,2,3.
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        run_job(3, -1, 0, 1'b0, "basic_k3");

        // Illegal lengths are ignored.
        idle_check(4, 1'b1, "bad_len");

        // Longest job; the final lane-3 address is K_MAX-1.
        run_job(K_MAX, -1, 0, 1'b0, "k_max");
        run_job(1, -1, 0, 1'b0, "k_one");

        // start held through the job, then a new start right after done.
        run_job(5, -1, 0, 1'b1, "start_held");
        run_job(2, -1, 0, 1'b0, "back_to_back");

        // Abort in FEED at t=2 (trace cycle 3).
        run_job(4, 3, 1, 1'b0, "abort_feed");
        idle_check(2, 1'b0, "after_abort");

        // Reset in READOUT (second readout cycle of a K=3 job), then a clean job.
        run_job(3, 1 + (3 + N - 1) + N*PE_LAT + 1, 2, 1'b0, "reset_readout");
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        run_job(3, -1, 0, 1'b0, "after_reset_k3");

        // Random jobs: random K, readout pacing, start noise and stops.
        for (int j = 0; j < 10; j++) begin
            k       = $urandom_range(1, 24);
            l0      = 1 + (k + N - 1) + N*PE_LAT + N;
            kind    = $urandom_range(0, 2);
            stop_at = (kind == 0) ? -1 : $urandom_range(0, l0 - 1);
            run_job(k, stop_at, kind, rnd_bit(), $sformatf("rand%0d", j));
            if ($urandom_range(0, 1) == 1) idle_check(1, 1'b1, "rand_idle");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
